// File: rtl/axi_wr_burst_shim_if.sv
// Write request port plus flattened AXI4 AW/W/B channels.
// master: the shim; slave: requester and interconnect side.
interface axi_wr_burst_shim_if #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int UserWidth = 1,
  parameter int IdWidth   = 4,
  parameter int NumWords  = 4
);
  localparam int BW = $clog2(NumWords);
  localparam int SW = DataWidth / 8;

  logic                          wr_req_i;
  logic                          wr_gnt_o;
  logic [AddrWidth-1:0]          wr_addr_i;
  logic [NumWords*DataWidth-1:0] wr_data_i;
  logic [NumWords*UserWidth-1:0] wr_user_i;
  logic [NumWords*SW-1:0]        wr_be_i;
  logic [BW-1:0]                 wr_blen_i;
  logic [2:0]                    wr_size_i;
  logic [IdWidth-1:0]            wr_id_i;
  logic                          wr_lock_i;
  logic [5:0]                    wr_atop_i;
  logic                          wr_valid_o;
  logic                          wr_rdy_i;
  logic [IdWidth-1:0]            wr_id_o;
  logic                          wr_exokay_o;
  logic                          wr_err_o;

  logic                 aw_valid_o;
  logic                 aw_ready_i;
  logic [AddrWidth-1:0] aw_addr_o;
  logic [7:0]           aw_len_o;
  logic [2:0]           aw_size_o;
  logic [1:0]           aw_burst_o;
  logic [IdWidth-1:0]   aw_id_o;
  logic                 aw_lock_o;
  logic [5:0]           aw_atop_o;

  logic                 w_valid_o;
  logic                 w_ready_i;
  logic [DataWidth-1:0] w_data_o;
  logic [SW-1:0]        w_strb_o;
  logic [UserWidth-1:0] w_user_o;
  logic                 w_last_o;

  logic                 b_valid_i;
  logic                 b_ready_o;
  logic [IdWidth-1:0]   b_id_i;
  logic [1:0]           b_resp_i;

  modport master (
    input  wr_req_i, wr_addr_i, wr_data_i, wr_user_i,
    input  wr_be_i, wr_blen_i, wr_size_i, wr_id_i,
    input  wr_lock_i, wr_atop_i, wr_rdy_i,
    input  aw_ready_i, w_ready_i,
    input  b_valid_i, b_id_i, b_resp_i,
    output wr_gnt_o, wr_valid_o, wr_id_o,
    output wr_exokay_o, wr_err_o,
    output aw_valid_o, aw_addr_o, aw_len_o, aw_size_o,
    output aw_burst_o, aw_id_o, aw_lock_o, aw_atop_o,
    output w_valid_o, w_data_o, w_strb_o, w_user_o,
    output w_last_o, b_ready_o
  );

  modport slave (
    output wr_req_i, wr_addr_i, wr_data_i, wr_user_i,
    output wr_be_i, wr_blen_i, wr_size_i, wr_id_i,
    output wr_lock_i, wr_atop_i, wr_rdy_i,
    output aw_ready_i, w_ready_i,
    output b_valid_i, b_id_i, b_resp_i,
    input  wr_gnt_o, wr_valid_o, wr_id_o,
    input  wr_exokay_o, wr_err_o,
    input  aw_valid_o, aw_addr_o, aw_len_o, aw_size_o,
    input  aw_burst_o, aw_id_o, aw_lock_o, aw_atop_o,
    input  w_valid_o, w_data_o, w_strb_o, w_user_o,
    input  w_last_o, b_ready_o
  );
endinterface

// File: rtl/axi_wr_burst_shim.sv
// Flattens a parallel multi-word write request into AXI4 AW/W/B.
// AW and W issue independently; B is passed straight back.
module axi_wr_burst_shim #(
  parameter int AddrWidth      = 64,
  parameter int DataWidth      = 64,
  parameter int UserWidth      = 1,
  parameter int IdWidth        = 4,
  parameter int NumWords       = 4,
  parameter int MaxOutstanding = 2
) (
  input logic clk_i,
  input logic rst_i,
  axi_wr_burst_shim_if.master bus
);
  localparam int BW = $clog2(NumWords);
  localparam int SW = DataWidth / 8;
  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                        state;
  logic [CW-1:0]                 out_cnt;
  logic [BW-1:0]                 beat;
  logic                          aw_pend;
  logic                          w_pend;
  logic [AddrWidth-1:0]          addr_q;
  logic [NumWords*DataWidth-1:0] data_q;
  logic [NumWords*UserWidth-1:0] user_q;
  logic [NumWords*SW-1:0]        be_q;
  logic [BW-1:0]                 blen_q;
  logic [2:0]                    size_q;
  logic [IdWidth-1:0]            id_q;
  logic                          lock_q;
  logic [5:0]                    atop_q;

  logic gnt, aw_hs, w_hs, b_hs, last;

  assign gnt   = (state == IDLE) & bus.wr_req_i
               & (out_cnt < MaxCnt);
  assign last  = w_pend & (beat == blen_q);
  assign aw_hs = aw_pend & bus.aw_ready_i;
  assign w_hs  = w_pend & bus.w_ready_i;
  assign b_hs  = bus.b_valid_i & bus.wr_rdy_i;

  assign bus.wr_gnt_o    = gnt;
  assign bus.aw_valid_o  = aw_pend;
  assign bus.aw_addr_o   = addr_q;
  assign bus.aw_len_o    = 8'(blen_q);
  assign bus.aw_size_o   = size_q;
  assign bus.aw_burst_o  = 2'b01;
  assign bus.aw_id_o     = id_q;
  assign bus.aw_lock_o   = lock_q;
  assign bus.aw_atop_o   = atop_q;
  assign bus.w_valid_o   = w_pend;
  assign bus.w_data_o    = data_q[beat*DataWidth +: DataWidth];
  assign bus.w_strb_o    = be_q[beat*SW +: SW];
  assign bus.w_user_o    = user_q[beat*UserWidth +: UserWidth];
  assign bus.w_last_o    = last;

  assign bus.wr_valid_o  = bus.b_valid_i;
  assign bus.b_ready_o   = bus.wr_rdy_i;
  assign bus.wr_id_o     = bus.b_id_i;
  assign bus.wr_exokay_o = (bus.b_resp_i == 2'b01);
  assign bus.wr_err_o    = bus.b_resp_i[1];

  // Request latch, AW/W pending flags and beat walk.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      beat    <= '0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      user_q  <= '0;
      be_q    <= '0;
      blen_q  <= '0;
      size_q  <= '0;
      id_q    <= '0;
      lock_q  <= 1'b0;
      atop_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt) begin
            addr_q  <= bus.wr_addr_i;
            data_q  <= bus.wr_data_i;
            user_q  <= bus.wr_user_i;
            be_q    <= bus.wr_be_i;
            blen_q  <= bus.wr_blen_i;
            size_q  <= bus.wr_size_i;
            id_q    <= bus.wr_id_i;
            lock_q  <= bus.wr_lock_i;
            atop_q  <= bus.wr_atop_i;
            beat    <= '0;
            aw_pend <= 1'b1;
            w_pend  <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (aw_hs) aw_pend <= 1'b0;
          if (w_hs) begin
            beat <= beat + BW'(1);
            if (last) w_pend <= 1'b0;
          end
          if ((!aw_pend || aw_hs) &&
              (!w_pend || (w_hs && last)))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bursts granted but not yet answered on B.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt <= '0;
    end else if (gnt && !b_hs) begin
      out_cnt <= out_cnt + CW'(1);
    end else if (!gnt && b_hs) begin
      out_cnt <= out_cnt - CW'(1);
    end
  end

  b_without_burst: assert property (
    @(posedge clk_i) disable iff (rst_i)
    b_hs |-> (out_cnt != '0));

endmodule

// File: tb/tb_axi_wr_burst_shim.sv
// Directed bench for axi_wr_burst_shim.
// Default parameters: 64-bit data, 4 words, 2 outstanding.
module tb_axi_wr_burst_shim;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  axi_wr_burst_shim_if bus ();

  axi_wr_burst_shim dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_req_i   = 1'b0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.wr_user_i  = '0;
    bus.wr_be_i    = '0;
    bus.wr_blen_i  = '0;
    bus.wr_size_i  = 3'd3;
    bus.wr_id_i    = '0;
    bus.wr_lock_i  = 1'b0;
    bus.wr_atop_i  = '0;
    bus.wr_rdy_i   = 1'b1;
    bus.aw_ready_i = 1'b1;
    bus.w_ready_i  = 1'b1;
    bus.b_valid_i  = 1'b0;
    bus.b_id_i     = '0;
    bus.b_resp_i   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    total++;
    if (bus.aw_valid_o !== 1'b0)
      $display("FAIL rst_awv got %b want 0", bus.aw_valid_o);
    else passed++;
    total++;
    if (bus.w_valid_o !== 1'b0)
      $display("FAIL rst_wv got %b want 0", bus.w_valid_o);
    else passed++;
    total++;
    if (bus.w_last_o !== 1'b0)
      $display("FAIL rst_wlast got %b want 0", bus.w_last_o);
    else passed++;
    total++;
    if (bus.wr_gnt_o !== 1'b0)
      $display("FAIL rst_gnt got %b want 0", bus.wr_gnt_o);
    else passed++;
    total++;
    if (bus.w_data_o !== 64'h0)
      $display("FAIL rst_wdata got %h want 0", bus.w_data_o);
    else passed++;
    total++;
    if (bus.aw_addr_o !== 64'h0)
      $display("FAIL rst_awaddr got %h want 0", bus.aw_addr_o);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.wr_req_i  = 1'b1;
    bus.wr_addr_i = 64'h1000;
    bus.wr_blen_i = 2'd0;
    bus.wr_data_i = {192'h0, 64'hAAAA_AAAA_AAAA_AAAA};
    bus.wr_be_i   = 32'h0000_00FF;
    bus.wr_id_i   = 4'd3;
    #1;
    total++;
    if (bus.wr_gnt_o !== 1'b1)
      $display("FAIL s_gnt got %b want 1", bus.wr_gnt_o);
    else passed++;
    cyc();
    bus.wr_req_i  = 1'b0;
    bus.wr_data_i = '1;
    #1;
    total++;
    if (bus.wr_gnt_o !== 1'b0)
      $display("FAIL s_gnt1 got %b want 0", bus.wr_gnt_o);
    else passed++;
    total++;
    if ({bus.aw_valid_o, bus.aw_len_o, bus.aw_id_o,
         bus.aw_burst_o} !== {1'b1, 8'd0, 4'd3, 2'b01})
      $display("FAIL s_aw got v%b len%0d id%0d b%b want v1 len0 id3 b01",
               bus.aw_valid_o, bus.aw_len_o, bus.aw_id_o,
               bus.aw_burst_o);
    else passed++;
    total++;
    if (bus.aw_addr_o !== 64'h1000)
      $display("FAIL s_awaddr got %h want 1000", bus.aw_addr_o);
    else passed++;
    total++;
    if ({bus.w_valid_o, bus.w_last_o, bus.w_strb_o} !==
        {1'b1, 1'b1, 8'hFF})
      $display("FAIL s_w got v%b l%b s%h want v1 l1 sFF",
               bus.w_valid_o, bus.w_last_o, bus.w_strb_o);
    else passed++;
    total++;
    if (bus.w_data_o !== 64'hAAAA_AAAA_AAAA_AAAA)
      $display("FAIL s_wdata got %h want AAAA..", bus.w_data_o);
    else passed++;
    cyc();
    total++;
    if ({bus.aw_valid_o, bus.w_valid_o} !== 2'b00)
      $display("FAIL s_done got %b want 00",
               {bus.aw_valid_o, bus.w_valid_o});
    else passed++;
    bus.b_valid_i = 1'b1;
    bus.b_resp_i  = 2'b00;
    bus.b_id_i    = 4'd3;
    bus.wr_rdy_i  = 1'b1;
    #1;
    total++;
    if ({bus.wr_valid_o, bus.wr_id_o, bus.wr_exokay_o,
         bus.wr_err_o, bus.b_ready_o} !==
        {1'b1, 4'd3, 1'b0, 1'b0, 1'b1})
      $display("FAIL s_b got v%b id%0d ex%b er%b r%b want v1 id3 ex0 er0 r1",
               bus.wr_valid_o, bus.wr_id_o, bus.wr_exokay_o,
               bus.wr_err_o, bus.b_ready_o);
    else passed++;
    cyc();
    bus.b_valid_i = 1'b0;
  endtask

  task automatic test_burst_stall();
    logic [63:0] ed [4];
    logic [7:0]  es [4];
    int b;
    ed[0] = 64'h1111_1111_1111_1111;
    ed[1] = 64'h2222_2222_2222_2222;
    ed[2] = 64'h3333_3333_3333_3333;
    ed[3] = 64'h4444_4444_4444_4444;
    es[0] = 8'h01;
    es[1] = 8'h03;
    es[2] = 8'h0F;
    es[3] = 8'hFF;
    do_reset();
    bus.wr_req_i  = 1'b1;
    bus.wr_addr_i = 64'h2000;
    bus.wr_blen_i = 2'd3;
    bus.wr_data_i = {ed[3], ed[2], ed[1], ed[0]};
    bus.wr_be_i   = {es[3], es[2], es[1], es[0]};
    #1;
    total++;
    if (bus.wr_gnt_o !== 1'b1)
      $display("FAIL bs_gnt got %b want 1", bus.wr_gnt_o);
    else passed++;
    cyc();
    bus.wr_req_i  = 1'b0;
    bus.wr_data_i = '0;
    bus.wr_be_i   = '0;
    for (int i = 0; i < 7; i++) begin
      b = (i + 1) / 2;
      bus.w_ready_i = (i % 2 == 0);
      #1;
      total++;
      if ({bus.w_valid_o, bus.w_data_o, bus.w_strb_o,
           bus.w_last_o} !== {1'b1, ed[b], es[b], b == 3})
        $display("FAIL bs_beat%0d got v%b d%h s%h l%b want v1 d%h s%h l%b",
                 i, bus.w_valid_o, bus.w_data_o, bus.w_strb_o,
                 bus.w_last_o, ed[b], es[b], b == 3);
      else passed++;
      cyc();
    end
    total++;
    if ({bus.aw_valid_o, bus.w_valid_o} !== 2'b00)
      $display("FAIL bs_done got %b want 00",
               {bus.aw_valid_o, bus.w_valid_o});
    else passed++;
    total++;
    if (bus.aw_len_o !== 8'd3)
      $display("FAIL bs_len got %0d want 3", bus.aw_len_o);
    else passed++;
    bus.w_ready_i = 1'b1;
  endtask

  task automatic test_w_before_aw();
    do_reset();
    bus.aw_ready_i = 1'b0;
    bus.wr_req_i   = 1'b1;
    bus.wr_addr_i  = 64'h3000;
    bus.wr_blen_i  = 2'd1;
    bus.wr_data_i  = {128'h0, 64'h6666_6666_6666_6666,
                      64'h5555_5555_5555_5555};
    bus.wr_be_i    = 32'h0000_FFFF;
    #1;
    total++;
    if (bus.wr_gnt_o !== 1'b1)
      $display("FAIL wa_gnt got %b want 1", bus.wr_gnt_o);
    else passed++;
    cyc();
    bus.wr_req_i = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      #1;
      total++;
      if ({bus.aw_valid_o, bus.aw_addr_o} !== {1'b1, 64'h3000})
        $display("FAIL wa_aw%0d got v%b a%h want v1 a3000",
                 i, bus.aw_valid_o, bus.aw_addr_o);
      else passed++;
      if (i == 1) begin
        total++;
        if ({bus.w_valid_o, bus.w_last_o, bus.w_data_o} !==
            {2'b10, 64'h5555_5555_5555_5555})
          $display("FAIL wa_w0 got v%b l%b d%h want v1 l0 d5555..",
                   bus.w_valid_o, bus.w_last_o, bus.w_data_o);
        else passed++;
      end
      if (i == 2) begin
        total++;
        if ({bus.w_valid_o, bus.w_last_o, bus.w_data_o} !==
            {2'b11, 64'h6666_6666_6666_6666})
          $display("FAIL wa_w1 got v%b l%b d%h want v1 l1 d6666..",
                   bus.w_valid_o, bus.w_last_o, bus.w_data_o);
        else passed++;
      end
      if (i == 3) begin
        total++;
        if (bus.w_valid_o !== 1'b0)
          $display("FAIL wa_wdone got %b want 0", bus.w_valid_o);
        else passed++;
      end
      cyc();
    end
    bus.aw_ready_i = 1'b1;
    bus.wr_req_i   = 1'b1;
    #1;
    total++;
    if ({bus.aw_valid_o, bus.wr_gnt_o} !== 2'b10)
      $display("FAIL wa_awhs got v%b g%b want v1 g0",
               bus.aw_valid_o, bus.wr_gnt_o);
    else passed++;
    cyc();
    total++;
    if ({bus.aw_valid_o, bus.wr_gnt_o} !== 2'b01)
      $display("FAIL wa_idle got v%b g%b want v0 g1",
               bus.aw_valid_o, bus.wr_gnt_o);
    else passed++;
    bus.wr_req_i = 1'b0;
    cyc();
  endtask

  task automatic test_outstanding();
    logic exp_g [14];
    logic bv [14];
    exp_g = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0};
    bv    = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    do_reset();
    bus.wr_addr_i = 64'h4000;
    bus.wr_blen_i = 2'd0;
    bus.b_id_i    = 4'd1;
    bus.wr_rdy_i  = 1'b1;
    for (int c = 0; c < 14; c++) begin
      bus.wr_req_i  = 1'b1;
      bus.b_valid_i = bv[c];
      #1;
      total++;
      if (bus.wr_gnt_o !== exp_g[c])
        $display("FAIL os_gnt_c%0d got %b want %b",
                 c, bus.wr_gnt_o, exp_g[c]);
      else passed++;
      cyc();
    end
    bus.wr_req_i  = 1'b0;
    bus.b_valid_i = 1'b0;
  endtask

  task automatic test_exclusive();
    do_reset();
    bus.wr_req_i  = 1'b1;
    bus.wr_addr_i = 64'h5000;
    bus.wr_lock_i = 1'b1;
    bus.wr_atop_i = 6'h21;
    bus.wr_id_i   = 4'd9;
    cyc();
    bus.wr_req_i  = 1'b0;
    bus.wr_lock_i = 1'b0;
    bus.wr_atop_i = '0;
    #1;
    total++;
    if ({bus.aw_lock_o, bus.aw_atop_o, bus.aw_id_o} !==
        {1'b1, 6'h21, 4'd9})
      $display("FAIL ex_aw got l%b a%h id%0d want l1 a21 id9",
               bus.aw_lock_o, bus.aw_atop_o, bus.aw_id_o);
    else passed++;
    cyc();
    bus.b_valid_i = 1'b1;
    bus.b_resp_i  = 2'b01;
    bus.b_id_i    = 4'd9;
    bus.wr_rdy_i  = 1'b1;
    #1;
    total++;
    if ({bus.wr_exokay_o, bus.wr_err_o, bus.wr_id_o} !==
        {2'b10, 4'd9})
      $display("FAIL ex_okay got ex%b er%b id%0d want ex1 er0 id9",
               bus.wr_exokay_o, bus.wr_err_o, bus.wr_id_o);
    else passed++;
    cyc();
    bus.b_resp_i = 2'b10;
    bus.wr_rdy_i = 1'b0;
    #1;
    total++;
    if ({bus.wr_valid_o, bus.wr_exokay_o, bus.wr_err_o,
         bus.b_ready_o} !== 4'b1010)
      $display("FAIL ex_slverr got v%b ex%b er%b r%b want v1 ex0 er1 r0",
               bus.wr_valid_o, bus.wr_exokay_o, bus.wr_err_o,
               bus.b_ready_o);
    else passed++;
    bus.b_resp_i = 2'b11;
    #1;
    total++;
    if ({bus.wr_exokay_o, bus.wr_err_o} !== 2'b01)
      $display("FAIL ex_decerr got ex%b er%b want ex0 er1",
               bus.wr_exokay_o, bus.wr_err_o);
    else passed++;
    bus.b_valid_i = 1'b0;
    bus.wr_rdy_i  = 1'b1;
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.aw_ready_i = 1'b0;
    bus.wr_req_i   = 1'b1;
    bus.wr_addr_i  = 64'h6000;
    bus.wr_blen_i  = 2'd3;
    bus.wr_data_i  = {64'hA3A3_A3A3_A3A3_A3A3,
                      64'hA2A2_A2A2_A2A2_A2A2,
                      64'hA1A1_A1A1_A1A1_A1A1,
                      64'hA0A0_A0A0_A0A0_A0A0};
    cyc();
    bus.wr_req_i = 1'b0;
    cyc();
    cyc();
    #1;
    total++;
    if ({bus.aw_valid_o, bus.w_valid_o, bus.w_data_o} !==
        {2'b11, 64'hA2A2_A2A2_A2A2_A2A2})
      $display("FAIL rm_beat2 got aw%b w%b d%h want aw1 w1 dA2A2..",
               bus.aw_valid_o, bus.w_valid_o, bus.w_data_o);
    else passed++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.aw_ready_i = 1'b1;
    bus.wr_blen_i  = 2'd0;
    bus.wr_req_i   = 1'b1;
    #1;
    total++;
    if ({bus.aw_valid_o, bus.w_valid_o, bus.w_last_o} !== 3'b000)
      $display("FAIL rm_clear got aw%b w%b l%b want 000",
               bus.aw_valid_o, bus.w_valid_o, bus.w_last_o);
    else passed++;
    total++;
    if ({bus.aw_addr_o, bus.w_data_o} !== 128'h0)
      $display("FAIL rm_payload got a%h d%h want 0 0",
               bus.aw_addr_o, bus.w_data_o);
    else passed++;
    total++;
    if (bus.wr_gnt_o !== 1'b1)
      $display("FAIL rm_gnt got %b want 1", bus.wr_gnt_o);
    else passed++;
    cyc();
    #1;
    total++;
    if (bus.wr_gnt_o !== 1'b0)
      $display("FAIL rm_busy got %b want 0", bus.wr_gnt_o);
    else passed++;
    cyc();
    #1;
    total++;
    if (bus.wr_gnt_o !== 1'b1)
      $display("FAIL rm_cnt got %b want 1", bus.wr_gnt_o);
    else passed++;
    bus.wr_req_i = 1'b0;
    cyc();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_burst_stall();
    test_w_before_aw();
    test_outstanding();
    test_exclusive();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
